pwr_rail_guard: RTL and testbench

//  Multi-channel, clocked eFuse/power-path supervisor; successor to the single-rail async fuse model.
//  Per channel: diode-path check (polarity, open/shorted diode), integrating overcurrent trip with

---
 rtl/pwr_pkg.sv | 18 +
 rtl/pwr_rail_ch.sv | 175 +++++++++++++++++
 rtl/pwr_rail_guard.sv | 83 ++++++++
 tb/tb_pwr_rail_guard.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwr_pkg.sv
// Shared types and helpers for the power-rail guard.
//   ch_state_e : per-channel supervisor state, 3-bit encoded, also exported on ch_state.
//   cnt_w()    : width of a counter that has to hold values 0..max_val.
package pwr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ON    = 3'd1,
    OC    = 3'd2,
    BLOWN = 3'd3,
    COOL  = 3'd4
  } ch_state_e;

  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pwr_rail_ch.sv
// One eFuse channel: diode-path check, integrating overcurrent trip,
// latch-off / auto-retry with cooldown, and a registered current report.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   pwr_ok_i                supply present
//   polarity_i              1 = reversed supply
//   diode_open_i            1 = diode blown open
//   diode_short_i           1 = diode shorted (conducts either way, beats diode_open)
//   load_ma_i [IW]          demanded load current, mA
//   force_blow_i            blow immediately and latch off
//   clear_i                 re-arm from BLOWN/COOL
//   powered_o               rail delivering power (registered)
//   fuse_blown_o            fuse open, BLOWN or COOL (registered)
//   state_o                 current FSM state
//   current_ma_o [IW]       reported current, 0 when not powered (registered)
module pwr_rail_ch
  import pwr_pkg::*;
#(
  parameter int IW         = 12,
  parameter int TRIP_MA    = 500,
  parameter int BLOW_CYC   = 1000,
  parameter int AUTO_RETRY = 1,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_CYC  = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pwr_ok_i,
  input  logic          polarity_i,
  input  logic          diode_open_i,
  input  logic          diode_short_i,
  input  logic [IW-1:0] load_ma_i,
  input  logic          force_blow_i,
  input  logic          clear_i,
  output logic          powered_o,
  output logic          fuse_blown_o,
  output ch_state_e     state_o,
  output logic [IW-1:0] current_ma_o
);

  localparam int OCW = cnt_w(BLOW_CYC);
  localparam int CW  = cnt_w(RETRY_CYC);
  localparam int RW  = cnt_w(MAX_RETRY);

  localparam logic [IW-1:0]  TRIP_LIM  = IW'(TRIP_MA);
  localparam logic [OCW-1:0] OC_LAST   = OCW'(BLOW_CYC - 1);
  localparam logic [CW-1:0]  CYC_LAST  = CW'(RETRY_CYC - 1);
  localparam logic [RW-1:0]  RETRY_MAX = RW'(MAX_RETRY);

  ch_state_e      state_q, state_d;
  logic [OCW-1:0] oc_cnt_q, oc_cnt_d;
  logic [CW-1:0]  cool_cnt_q, cool_cnt_d;
  logic [CW-1:0]  on_cnt_q, on_cnt_d;     // consecutive cycles spent in ON/OC
  logic [RW-1:0]  retry_cnt_q, retry_cnt_d;
  logic           powered_q, fuse_blown_q;
  logic [IW-1:0]  current_q;

  logic path, over, powered_d;

  assign path = pwr_ok_i & (diode_short_i | (~diode_open_i & ~polarity_i));
  assign over = load_ma_i > TRIP_LIM;

  // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    oc_cnt_d    = oc_cnt_q;
    cool_cnt_d  = cool_cnt_q;
    on_cnt_d    = '0;
    retry_cnt_d = retry_cnt_q;

    // A long enough healthy stretch forgives earlier retries.
    if (state_q == ON || state_q == OC) begin
      if (on_cnt_q == CYC_LAST) begin
        on_cnt_d    = on_cnt_q;
        retry_cnt_d = '0;
      end else begin
        on_cnt_d = on_cnt_q + 1'b1;
      end
    end

    unique case (state_q)
      IDLE: if (path) state_d = ON;
      ON: begin
        if (!path) begin
          state_d = IDLE;
        end else if (over) begin
          if (BLOW_CYC == 1) begin
            state_d = BLOWN;
          end else begin
            state_d  = OC;
            oc_cnt_d = OCW'(1);
          end
        end
      end
      OC: begin
        if (!path) begin
          state_d  = IDLE;
          oc_cnt_d = '0;
        end else if (!over) begin
          state_d  = ON;
          oc_cnt_d = '0;
        end else if (oc_cnt_q == OC_LAST) begin
          state_d  = BLOWN;
          oc_cnt_d = '0;
        end else begin
          oc_cnt_d = oc_cnt_q + 1'b1;
        end
      end
      BLOWN: begin
        if (AUTO_RETRY != 0 && retry_cnt_q < RETRY_MAX) begin
          state_d    = COOL;
          cool_cnt_d = '0;
        end
      end
      COOL: begin
        if (cool_cnt_q == CYC_LAST) begin
          state_d    = IDLE;
          cool_cnt_d = '0;
          if (retry_cnt_q != RETRY_MAX) retry_cnt_d = retry_cnt_q + 1'b1;
        end else begin
          cool_cnt_d = cool_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear_i && (state_q == BLOWN || state_q == COOL)) begin
      state_d     = IDLE;
      retry_cnt_d = '0;
      oc_cnt_d    = '0;
      cool_cnt_d  = '0;
      on_cnt_d    = '0;
    end

    // Test blow wins over clear and pins the retry budget so it latches off.
    if (force_blow_i) begin
      state_d     = BLOWN;
      retry_cnt_d = RETRY_MAX;
      oc_cnt_d    = '0;
      cool_cnt_d  = '0;
      on_cnt_d    = '0;
    end
  end

  assign powered_d = (state_d == ON) || (state_d == OC);

  // NOTE: reset is sampled on the clock edge (synchronous), and all state uses non-blocking assignment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      oc_cnt_q     <= '0;
      cool_cnt_q   <= '0;
      on_cnt_q     <= '0;
      retry_cnt_q  <= '0;
      powered_q    <= 1'b0;
      fuse_blown_q <= 1'b0;
      current_q    <= '0;
    end else begin
      state_q      <= state_d;
      oc_cnt_q     <= oc_cnt_d;
      cool_cnt_q   <= cool_cnt_d;
      on_cnt_q     <= on_cnt_d;
      retry_cnt_q  <= retry_cnt_d;
      powered_q    <= powered_d;
      fuse_blown_q <= (state_d == BLOWN) || (state_d == COOL);
      current_q    <= powered_d ? load_ma_i : '0;
    end
  end

  assign powered_o    = powered_q;
  assign fuse_blown_o = fuse_blown_q;
  assign state_o      = state_q;
  assign current_ma_o = current_q;

endmodule

// File: rtl/pwr_rail_guard.sv
// Multi-channel clocked eFuse / power-path supervisor, one pwr_rail_ch per rail.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   pwr_ok                      supply present, shared by all channels
//   polarity/diode_open/diode_short [NCH]  per-channel path faults
//   load_ma [NCH*IW]            demanded current, ch i at [i*IW +: IW]
//   force_blow/clear [NCH]      test blow / operator re-arm
//   powered/fuse_blown [NCH]    per-channel status
//   ch_state [NCH*3]            per-channel pwr_pkg::ch_state_e
//   current_ma [NCH*IW]         reported per-channel current
//   total_ma [IW+clog2(NCH)]    registered sum of current_ma (one cycle later)
//   any_blown                   OR of fuse_blown
module pwr_rail_guard
  import pwr_pkg::*;
#(
  parameter int NCH        = 4,
  parameter int IW         = 12,
  parameter int TRIP_MA    = 500,
  parameter int BLOW_CYC   = 1000,
  parameter int AUTO_RETRY = 1,
  parameter int MAX_RETRY  = 3,
  parameter int RETRY_CYC  = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       pwr_ok,
  input  logic [NCH-1:0]             polarity,
  input  logic [NCH-1:0]             diode_open,
  input  logic [NCH-1:0]             diode_short,
  input  logic [NCH*IW-1:0]          load_ma,
  input  logic [NCH-1:0]             force_blow,
  input  logic [NCH-1:0]             clear,
  output logic [NCH-1:0]             powered,
  output logic [NCH-1:0]             fuse_blown,
  output logic [NCH*3-1:0]           ch_state,
  output logic [NCH*IW-1:0]          current_ma,
  output logic [IW+$clog2(NCH)-1:0]  total_ma,
  output logic                       any_blown
);

  localparam int TW = IW + $clog2(NCH);

  logic [TW-1:0] total_q, total_d;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_state_e st;

    pwr_rail_ch #(
      .IW(IW), .TRIP_MA(TRIP_MA), .BLOW_CYC(BLOW_CYC),
      .AUTO_RETRY(AUTO_RETRY), .MAX_RETRY(MAX_RETRY), .RETRY_CYC(RETRY_CYC)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .pwr_ok_i     (pwr_ok),
      .polarity_i   (polarity[i]),
      .diode_open_i (diode_open[i]),
      .diode_short_i(diode_short[i]),
      .load_ma_i    (load_ma[i*IW +: IW]),
      .force_blow_i (force_blow[i]),
      .clear_i      (clear[i]),
      .powered_o    (powered[i]),
      .fuse_blown_o (fuse_blown[i]),
      .state_o      (st),
      .current_ma_o (current_ma[i*IW +: IW])
    );

    assign ch_state[i*3 +: 3] = st;
  end

  always_comb begin
    total_d = '0;
    for (int i = 0; i < NCH; i++) total_d = total_d + TW'(current_ma[i*IW +: IW]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) total_q <= '0;
    else        total_q <= total_d;
  end

  assign total_ma  = total_q;
  assign any_blown = |fuse_blown;

endmodule

// File: tb/tb_pwr_rail_guard.sv
// Directed bench for pwr_rail_guard: two instances share the stimulus,
// dut_a with auto-retry and dut_b latching off (AUTO_RETRY=0).
module tb_pwr_rail_guard;

  localparam int NCH = 4;
  localparam int IW  = 12;
  localparam int TW  = IW + 2;

  localparam int S_IDLE  = 0;
  localparam int S_ON    = 1;
  localparam int S_OC    = 2;
  localparam int S_BLOWN = 3;
  localparam int S_COOL  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pwr_ok;
  logic [NCH-1:0]    polarity, diode_open, diode_short, force_blow, clear;
  logic [NCH*IW-1:0] load_ma;

  logic [NCH-1:0]    a_powered, a_fuse_blown, b_powered, b_fuse_blown;
  logic [NCH*3-1:0]  a_ch_state, b_ch_state;
  logic [NCH*IW-1:0] a_current_ma, b_current_ma;
  logic [TW-1:0]     a_total_ma, b_total_ma;
  logic              a_any_blown, b_any_blown;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pwr_rail_guard #(
    .NCH(NCH), .IW(IW), .TRIP_MA(500), .BLOW_CYC(8),
    .AUTO_RETRY(1), .MAX_RETRY(2), .RETRY_CYC(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pwr_ok(pwr_ok), .polarity(polarity),
    .diode_open(diode_open), .diode_short(diode_short), .load_ma(load_ma),
    .force_blow(force_blow), .clear(clear), .powered(a_powered),
    .fuse_blown(a_fuse_blown), .ch_state(a_ch_state), .current_ma(a_current_ma),
    .total_ma(a_total_ma), .any_blown(a_any_blown)
  );

  pwr_rail_guard #(
    .NCH(NCH), .IW(IW), .TRIP_MA(500), .BLOW_CYC(8),
    .AUTO_RETRY(0), .MAX_RETRY(2), .RETRY_CYC(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pwr_ok(pwr_ok), .polarity(polarity),
    .diode_open(diode_open), .diode_short(diode_short), .load_ma(load_ma),
    .force_blow(force_blow), .clear(clear), .powered(b_powered),
    .fuse_blown(b_fuse_blown), .ch_state(b_ch_state), .current_ma(b_current_ma),
    .total_ma(b_total_ma), .any_blown(b_any_blown)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_load(input int ch, input int v);
    load_ma[ch*IW +: IW] = IW'(v);
  endtask

  function automatic logic [31:0] st_a(input int ch);
    return 32'(a_ch_state[ch*3 +: 3]);
  endfunction

  function automatic logic [31:0] st_b(input int ch);
    return 32'(b_ch_state[ch*3 +: 3]);
  endfunction

  function automatic logic [31:0] cur_a(input int ch);
    return 32'(a_current_ma[ch*IW +: IW]);
  endfunction

  initial begin
    rst_n       = 1'b0;
    pwr_ok      = 1'b1;
    polarity    = '0;
    diode_open  = '0;
    diode_short = '0;
    force_blow  = '0;
    clear       = '0;
    load_ma     = '0;
    set_load(0, 120);
    set_load(2, 300);

    // Reset state
    step(2);
    check("rst_powered",  32'(a_powered), 0);
    check("rst_current",  32'(a_current_ma), 0);
    check("rst_total",    32'(a_total_ma), 0);
    check("rst_anyblown", 32'(a_any_blown), 0);
    check("rst_state",    32'(a_ch_state), 0);

    // 1: basic power-up, total one cycle behind current
    rst_n = 1'b1;
    step(1);
    check("up_state0",   st_a(0), S_ON);
    check("up_powered",  32'(a_powered), 32'hF);
    check("up_cur0",     cur_a(0), 120);
    check("up_cur2",     cur_a(2), 300);
    check("up_total_lag", 32'(a_total_ma), 0);
    step(1);
    check("up_total",    32'(a_total_ma), 420);

    // 2: reversed polarity, diode short override, open diode
    polarity[0] = 1'b1;
    step(1);
    check("rev_powered0", 32'(a_powered[0]), 0);
    check("rev_cur0",     cur_a(0), 0);
    check("rev_state0",   st_a(0), S_IDLE);
    diode_short[0] = 1'b1;
    step(1);
    check("short_powered0", 32'(a_powered[0]), 1);
    check("short_cur0",     cur_a(0), 120);
    diode_short[0] = 1'b0;
    polarity[0]    = 1'b0;
    diode_open[0]  = 1'b1;
    step(1);
    check("open_powered0", 32'(a_powered[0]), 0);
    check("open_cur0",     cur_a(0), 0);
    diode_open[0] = 1'b0;
    step(1);
    check("reclose_state0", st_a(0), S_ON);

    // 3: 7 over samples then recover, then 8 over samples blow
    set_load(0, 2000);
    step(7);
    check("oc7_state0", st_a(0), S_OC);
    check("oc7_blown0", 32'(a_fuse_blown[0]), 0);
    check("oc7_cur0",   cur_a(0), 2000);
    set_load(0, 480);
    step(1);
    check("recover_state0", st_a(0), S_ON);
    set_load(0, 2000);
    step(7);
    check("oc_again_state0", st_a(0), S_OC);
    step(1);
    check("blow1_state0",  st_a(0), S_BLOWN);
    check("blow1_fuse0",   32'(a_fuse_blown[0]), 1);
    check("blow1_pow0",    32'(a_powered[0]), 0);
    check("blow1_cur0",    cur_a(0), 0);
    check("blow1_any",     32'(a_any_blown), 1);
    check("blow1_b_state0", st_b(0), S_BLOWN);

    // 4: auto-retry cycles, third blow latches, clear re-arms
    step(1);
    check("cool1_state0", st_a(0), S_COOL);
    check("cool1_fuse0",  32'(a_fuse_blown[0]), 1);
    check("b_latched0",   st_b(0), S_BLOWN);
    step(15);
    check("cool1_end_state0", st_a(0), S_COOL);
    step(1);
    check("retry1_state0", st_a(0), S_IDLE);
    check("retry1_fuse0",  32'(a_fuse_blown[0]), 0);
    step(9);
    check("blow2_state0", st_a(0), S_BLOWN);
    step(1);
    check("cool2_state0", st_a(0), S_COOL);
    step(16);
    check("retry2_state0", st_a(0), S_IDLE);
    step(9);
    check("blow3_state0", st_a(0), S_BLOWN);
    step(1);
    check("latch3_state0", st_a(0), S_BLOWN);
    step(20);
    check("latch3_hold0", st_a(0), S_BLOWN);
    check("b_hold0",      st_b(0), S_BLOWN);
    set_load(0, 120);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    check("clear_state0",   st_a(0), S_IDLE);
    check("clear_b_state0", st_b(0), S_IDLE);
    step(1);
    check("rearm_state0", st_a(0), S_ON);
    check("rearm_cur0",   cur_a(0), 120);
    // retry budget restored: a fresh blow goes to COOL again
    set_load(0, 2000);
    step(8);
    check("blow4_state0", st_a(0), S_BLOWN);
    step(1);
    check("cool4_state0", st_a(0), S_COOL);
    check("b_nocool0",    st_b(0), S_BLOWN);
    set_load(0, 120);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    step(1);
    check("rearm2_state0", st_a(0), S_ON);

    // 5: force_blow and clear together in ON -> latched BLOWN
    force_blow[0] = 1'b1;
    clear[0]      = 1'b1;
    step(1);
    force_blow[0] = 1'b0;
    clear[0]      = 1'b0;
    check("force_state0", st_a(0), S_BLOWN);
    step(1);
    check("force_nocool0", st_a(0), S_BLOWN);
    step(5);
    check("force_hold0", st_a(0), S_BLOWN);
    clear[0] = 1'b1;
    step(1);
    clear[0] = 1'b0;
    check("force_clear0", st_a(0), S_IDLE);
    step(1);
    check("force_rearm0", st_a(0), S_ON);
    step(1);
    check("force_total", 32'(a_total_ma), 420);

    // Trip threshold is strict: 500 is fine, 501 is over
    set_load(3, 500);
    step(10);
    check("trip500_state3", st_a(3), S_ON);
    check("trip500_cur3",   cur_a(3), 500);
    set_load(3, 501);
    step(1);
    check("trip501_state3", st_a(3), S_OC);
    set_load(3, 0);
    step(1);
    check("trip_back_state3", st_a(3), S_ON);

    // 6: reset mid-COOL on ch1 while ch0 ON; latch-off instance stays BLOWN until reset
    set_load(1, 2000);
    step(8);
    check("ch1_blow_a", st_a(1), S_BLOWN);
    check("ch1_blow_b", st_b(1), S_BLOWN);
    step(4);
    check("ch1_cool_a",  st_a(1), S_COOL);
    check("ch1_latch_b", st_b(1), S_BLOWN);
    check("ch0_indep",   st_a(0), S_ON);
    check("ch2_indep",   cur_a(2), 300);
    set_load(1, 0);
    rst_n = 1'b0;
    step(1);
    check("rst2_powered_a", 32'(a_powered), 0);
    check("rst2_fuse_a",    32'(a_fuse_blown), 0);
    check("rst2_state_a",   32'(a_ch_state), 0);
    check("rst2_cur_a",     32'(a_current_ma), 0);
    check("rst2_total_a",   32'(a_total_ma), 0);
    check("rst2_any_a",     32'(a_any_blown), 0);
    check("rst2_state_b",   32'(b_ch_state), 0);
    check("rst2_any_b",     32'(b_any_blown), 0);
    rst_n = 1'b1;
    step(1);
    check("post_rst_cur0", cur_a(0), 120);
    check("post_rst_b1",   st_b(1), S_ON);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
